regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 96 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with register-file scoreboard
module regfile_wb_arbiter (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        IssueValid,
  input  logic [4:0]  IssueWn,
  input  logic        AluValid,
  input  logic [4:0]  AluWn,
  input  logic [31:0] AluWd,
  output logic        AluReady,
  input  logic        MemValid,
  input  logic [4:0]  MemWn,
  input  logic [31:0] MemWd,
  output logic        MemReady,
  output logic        Write,
  output logic [4:0]  Wn,
  output logic [31:0] Wd,
  input  logic [4:0]  Rn1,
  input  logic [4:0]  Rn2,
  output logic        Busy1,
  output logic        Busy2,
  output logic [31:0] Pending,
  output logic        Idle
);

  typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

  grant_e      last_grant_q, last_grant_d;
  logic        write_q, write_d;
  logic [4:0]  wn_q, wn_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] pending_q, pending_d;

  logic        alu_ready, mem_ready, transfer;
  logic [4:0]  sel_wn;
  logic [31:0] sel_wd;

  // Readies are gated by Resetn so nothing handshakes while reset is held.
  always_comb begin
    alu_ready = Resetn && AluValid && (!MemValid || (last_grant_q == GRANT_MEM));
    mem_ready = Resetn && MemValid && (!AluValid || (last_grant_q == GRANT_ALU));
    transfer  = alu_ready || mem_ready;
    sel_wn    = alu_ready ? AluWn : MemWn;
    sel_wd    = alu_ready ? AluWd : MemWd;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_ready) begin
      last_grant_d = GRANT_ALU;
    end else if (mem_ready) begin
      last_grant_d = GRANT_MEM;
    end

    write_d = transfer && (sel_wn != 5'd0);
    wn_d    = write_d ? sel_wn : wn_q;
    wd_d    = write_d ? sel_wd : wd_q;

    // Clear on commit first, then set, so a same-edge issue wins.
    pending_d = pending_q;
    if (write_q) begin
      pending_d[wn_q] = 1'b0;
    end
    if (IssueValid && (IssueWn != 5'd0)) begin
      pending_d[IssueWn] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_grant_q <= GRANT_MEM;
      write_q      <= 1'b0;
      wn_q         <= 5'd0;
      wd_q         <= 32'd0;
      pending_q    <= 32'd0;
    end else begin
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      wn_q         <= wn_d;
      wd_q         <= wd_d;
      pending_q    <= pending_d;
    end
  end

  assign AluReady = alu_ready;
  assign MemReady = mem_ready;
  assign Write    = write_q;
  assign Wn       = wn_q;
  assign Wd       = wd_q;
  assign Pending  = pending_q;
  assign Busy1    = pending_q[Rn1];
  assign Busy2    = pending_q[Rn2];
  assign Idle     = (pending_q == 32'd0) && !write_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        IssueValid, AluValid, MemValid;
  logic [4:0]  IssueWn, AluWn, MemWn, Rn1, Rn2;
  logic [31:0] AluWd, MemWd;
  logic        AluReady, MemReady, Write, Busy1, Busy2, Idle;
  logic [4:0]  Wn;
  logic [31:0] Wd, Pending;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter dut (
    .Clock(Clock), .Resetn(Resetn),
    .IssueValid(IssueValid), .IssueWn(IssueWn),
    .AluValid(AluValid), .AluWn(AluWn), .AluWd(AluWd), .AluReady(AluReady),
    .MemValid(MemValid), .MemWn(MemWn), .MemWd(MemWd), .MemReady(MemReady),
    .Write(Write), .Wn(Wn), .Wd(Wd),
    .Rn1(Rn1), .Rn2(Rn2), .Busy1(Busy1), .Busy2(Busy2),
    .Pending(Pending), .Idle(Idle)
  );

  always #5 Clock = ~Clock;

  task automatic clear_inputs();
    IssueValid = 0; IssueWn = 0;
    AluValid = 0; AluWn = 0; AluWd = 0;
    MemValid = 0; MemWn = 0; MemWd = 0;
    Rn1 = 0; Rn2 = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 0;
    clear_inputs();
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1;
  endtask

  task automatic test_reset();
    Resetn = 0;
    clear_inputs();
    AluValid = 1; MemValid = 1; AluWn = 3; MemWn = 4;
    #2;
    n_cmp++; if (AluReady !== 1'b0) begin n_bad++; $display("FAIL reset_alu_ready got %b want 0", AluReady); end
    n_cmp++; if (MemReady !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready got %b want 0", MemReady); end
    n_cmp++; if (Write !== 1'b0) begin n_bad++; $display("FAIL reset_write got %b want 0", Write); end
    n_cmp++; if (Wn !== 5'd0) begin n_bad++; $display("FAIL reset_wn got %0d want 0", Wn); end
    n_cmp++; if (Wd !== 32'd0) begin n_bad++; $display("FAIL reset_wd got %h want 0", Wd); end
    n_cmp++; if (Pending !== 32'd0) begin n_bad++; $display("FAIL reset_pending got %h want 0", Pending); end
    n_cmp++; if (Idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got %b want 1", Idle); end
  endtask

  task automatic test_single();
    do_reset();
    AluValid = 1; AluWn = 5; AluWd = 32'h11;
    #1;
    n_cmp++; if (AluReady !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", AluReady); end
    tick();
    AluValid = 0;
    n_cmp++; if (Write !== 1'b1) begin n_bad++; $display("FAIL single_write got %b want 1", Write); end
    n_cmp++; if (Wn !== 5'd5) begin n_bad++; $display("FAIL single_wn got %0d want 5", Wn); end
    n_cmp++; if (Wd !== 32'h11) begin n_bad++; $display("FAIL single_wd got %h want 11", Wd); end
    tick();
    n_cmp++; if (Write !== 1'b0) begin n_bad++; $display("FAIL single_write_drop got %b want 0", Write); end
  endtask

  task automatic test_round_robin();
    int exp_wn[4] = '{1, 9, 2, 10};
    int a_idx = 1;
    int m_idx = 9;
    logic [4:0] got;
    do_reset();
    AluValid = 1; MemValid = 1;
    for (int i = 0; i < 4; i++) begin
      AluWn = 5'(a_idx); AluWd = 32'(100 + a_idx);
      MemWn = 5'(m_idx); MemWd = 32'(200 + m_idx);
      #1;
      n_cmp++; if ((AluReady ^ MemReady) !== 1'b1) begin n_bad++; $display("FAIL rr_one_ready[%0d] got alu=%b mem=%b want exactly one", i, AluReady, MemReady); end
      got = AluReady ? AluWn : MemWn;
      n_cmp++; if (got !== 5'(exp_wn[i])) begin n_bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, got, exp_wn[i]); end
      if (AluReady) a_idx++;
      if (MemReady) m_idx++;
      tick();
      n_cmp++; if (Write !== 1'b1 || Wn !== 5'(exp_wn[i])) begin n_bad++; $display("FAIL rr_write[%0d] got write=%b wn=%0d want write=1 wn=%0d", i, Write, Wn, exp_wn[i]); end
    end
    AluValid = 0; MemValid = 0;
  endtask

  task automatic test_scoreboard();
    do_reset();
    IssueValid = 1; IssueWn = 7;
    tick();
    IssueValid = 0; Rn1 = 7;
    #1;
    n_cmp++; if (Busy1 !== 1'b1) begin n_bad++; $display("FAIL sb_busy_set got %b want 1", Busy1); end
    MemValid = 1; MemWn = 7; MemWd = 32'hABCD;
    #1;
    n_cmp++; if (MemReady !== 1'b1) begin n_bad++; $display("FAIL sb_mem_ready got %b want 1", MemReady); end
    tick();
    MemValid = 0;
    n_cmp++; if (Write !== 1'b1 || Wn !== 5'd7 || Wd !== 32'hABCD) begin n_bad++; $display("FAIL sb_write got write=%b wn=%0d wd=%h want 1/7/abcd", Write, Wn, Wd); end
    n_cmp++; if (Busy1 !== 1'b1) begin n_bad++; $display("FAIL sb_busy_during_write got %b want 1", Busy1); end
    tick();
    n_cmp++; if (Busy1 !== 1'b0) begin n_bad++; $display("FAIL sb_busy_clear got %b want 0", Busy1); end
    n_cmp++; if (Idle !== 1'b1) begin n_bad++; $display("FAIL sb_idle got %b want 1", Idle); end
  endtask

  task automatic test_set_clear_same();
    do_reset();
    IssueValid = 1; IssueWn = 3;
    tick();
    IssueValid = 0;
    MemValid = 1; MemWn = 3; MemWd = 32'h33;
    tick();
    MemValid = 0;
    n_cmp++; if (Write !== 1'b1 || Wn !== 5'd3) begin n_bad++; $display("FAIL sc_write got write=%b wn=%0d want 1/3", Write, Wn); end
    IssueValid = 1; IssueWn = 3;
    tick();
    IssueValid = 0; Rn2 = 3;
    #1;
    n_cmp++; if (Pending[3] !== 1'b1) begin n_bad++; $display("FAIL sc_pending3 got %b want 1", Pending[3]); end
    n_cmp++; if (Busy2 !== 1'b1) begin n_bad++; $display("FAIL sc_busy2 got %b want 1", Busy2); end
  endtask

  task automatic test_wn_zero();
    do_reset();
    AluValid = 1; AluWn = 5; AluWd = 32'h22;
    tick();
    AluValid = 0;
    MemValid = 1; MemWn = 0; MemWd = 32'hFF;
    #1;
    n_cmp++; if (MemReady !== 1'b1) begin n_bad++; $display("FAIL wz_ready got %b want 1", MemReady); end
    tick();
    MemValid = 0;
    n_cmp++; if (Write !== 1'b0) begin n_bad++; $display("FAIL wz_write got %b want 0", Write); end
    n_cmp++; if (Wn !== 5'd5 || Wd !== 32'h22) begin n_bad++; $display("FAIL wz_hold got wn=%0d wd=%h want 5/22", Wn, Wd); end
    n_cmp++; if (Idle !== 1'b1) begin n_bad++; $display("FAIL wz_idle got %b want 1", Idle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    IssueValid = 1; IssueWn = 4;
    tick();
    IssueValid = 0;
    AluValid = 1; AluWn = 6; AluWd = 32'h66;
    tick();
    AluWn = 8; AluWd = 32'h88; Rn1 = 4;
    #1;
    n_cmp++; if (AluReady !== 1'b1 || Write !== 1'b1 || Busy1 !== 1'b1) begin n_bad++; $display("FAIL mid_pre got ready=%b write=%b busy=%b want 1/1/1", AluReady, Write, Busy1); end
    #1;
    Resetn = 0;
    #1;
    n_cmp++; if (Write !== 1'b0) begin n_bad++; $display("FAIL mid_write got %b want 0", Write); end
    n_cmp++; if (Pending !== 32'd0 || Busy1 !== 1'b0) begin n_bad++; $display("FAIL mid_pending got %h busy=%b want 0/0", Pending, Busy1); end
    n_cmp++; if (Idle !== 1'b1 || AluReady !== 1'b0) begin n_bad++; $display("FAIL mid_idle got idle=%b ready=%b want 1/0", Idle, AluReady); end
    AluValid = 0;
    @(posedge Clock);
    #1;
    Resetn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (Write !== 1'b0 || Pending !== 32'd0) begin n_bad++; $display("FAIL mid_after[%0d] got write=%b pending=%h want 0/0", i, Write, Pending); end
    end
  endtask

  task automatic test_random();
    bit          pend[32];
    bit          mem_won_last;
    bit          e_write;
    logic [4:0]  e_wn;
    logic [31:0] e_wd;
    logic [31:0] e_pend;
    bit          e_ar, e_mr;
    do_reset();
    foreach (pend[i]) pend[i] = 0;
    mem_won_last = 1;
    e_write = 0; e_wn = 0; e_wd = 0;
    for (int c = 0; c < 300; c++) begin
      IssueValid = 1'($urandom_range(0, 1));
      IssueWn    = 5'($urandom_range(0, 15));
      AluValid   = 1'($urandom_range(0, 1));
      AluWn      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      AluWd      = $urandom;
      MemValid   = 1'($urandom_range(0, 1));
      MemWn      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      MemWd      = $urandom;
      Rn1        = 5'($urandom_range(0, 15));
      Rn2        = 5'($urandom_range(0, 15));
      #1;
      e_ar = AluValid && (!MemValid || mem_won_last);
      e_mr = MemValid && (!AluValid || !mem_won_last);
      for (int i = 0; i < 32; i++) e_pend[i] = pend[i];
      n_cmp++; if (AluReady !== e_ar || MemReady !== e_mr) begin n_bad++; $display("FAIL rnd_ready[%0d] got alu=%b mem=%b want %b/%b", c, AluReady, MemReady, e_ar, e_mr); end
      n_cmp++; if (Write !== e_write || Wn !== e_wn || Wd !== e_wd) begin n_bad++; $display("FAIL rnd_port[%0d] got %b/%0d/%h want %b/%0d/%h", c, Write, Wn, Wd, e_write, e_wn, e_wd); end
      n_cmp++; if (Pending !== e_pend) begin n_bad++; $display("FAIL rnd_pending[%0d] got %h want %h", c, Pending, e_pend); end
      n_cmp++; if (Busy1 !== pend[Rn1] || Busy2 !== pend[Rn2]) begin n_bad++; $display("FAIL rnd_busy[%0d] got %b/%b want %b/%b", c, Busy1, Busy2, pend[Rn1], pend[Rn2]); end
      n_cmp++; if (Idle !== (e_pend == 0 && !e_write)) begin n_bad++; $display("FAIL rnd_idle[%0d] got %b", c, Idle); end
      if (e_write) pend[e_wn] = 0;
      if (IssueValid && IssueWn != 0) pend[IssueWn] = 1;
      e_write = 0;
      if (e_ar || e_mr) begin
        mem_won_last = e_mr;
        if ((e_ar ? AluWn : MemWn) != 0) begin
          e_write = 1;
          e_wn = e_ar ? AluWn : MemWn;
          e_wd = e_ar ? AluWd : MemWd;
        end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_set_clear_same();
    test_wn_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
